// File: rtl/sorter_if.sv
// Handshake/data bundle for the sorter: one packed set in, one sorted set out.
// The master side drives sets in and observes results; the slave side is the sorter.
interface sorter_if #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 8
);
  logic           in_valid;
  logic [N*W-1:0] sortIn;
  logic           out_valid;
  logic [N*W-1:0] sortOut;

  modport master (
    output in_valid,
    output sortIn,
    input  out_valid,
    input  sortOut
  );

  modport slave (
    input  in_valid,
    input  sortIn,
    output out_valid,
    output sortOut
  );
endinterface

// File: rtl/sorter.sv
// Pipelined 8-element Batcher odd-even merge sorter.
// It uses 19 compare-exchange units in 6 layers, with a register stage after
// every second layer, so a set presented at edge n is visible after edge n+2.
// Data registers load every cycle. in_valid travels beside the data in a
// 3-bit shift chain.
// Optional: define SORTER_DESCENDING_EN to put the largest element in lane 0.
module sorter #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  sorter_if.slave  bus
);

  typedef logic [N-1:0][W-1:0] lanes_t;

  // Compare-exchange on lanes i<j; equal values fall through unchanged.
  function automatic lanes_t cx(input lanes_t a, input int i, input int j);
    lanes_t       r;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    r  = a;
    lo = (a[i] <= a[j]) ? a[i] : a[j];
    hi = (a[i] <= a[j]) ? a[j] : a[i];
`ifdef SORTER_DESCENDING_EN
    r[i] = hi;
    r[j] = lo;
`else
    r[i] = lo;
    r[j] = hi;
`endif
    return r;
  endfunction

  lanes_t     s1_d, s1_q;
  lanes_t     s2_d, s2_q;
  lanes_t     s3_d, s3_q;
  logic [2:0] vld_q;

  // Layers 1-2 on the incoming set.
  always_comb begin
    s1_d = bus.sortIn;
    s1_d = cx(s1_d, 0, 1);
    s1_d = cx(s1_d, 2, 3);
    s1_d = cx(s1_d, 4, 5);
    s1_d = cx(s1_d, 6, 7);
    s1_d = cx(s1_d, 0, 2);
    s1_d = cx(s1_d, 1, 3);
    s1_d = cx(s1_d, 4, 6);
    s1_d = cx(s1_d, 5, 7);
  end

  // Layers 3-4: finish the two sorted halves of 4, then start the merge.
  always_comb begin
    s2_d = s1_q;
    s2_d = cx(s2_d, 1, 2);
    s2_d = cx(s2_d, 5, 6);
    s2_d = cx(s2_d, 0, 4);
    s2_d = cx(s2_d, 1, 5);
    s2_d = cx(s2_d, 2, 6);
    s2_d = cx(s2_d, 3, 7);
  end

  // Layers 5-6: final cleanup of the merge.
  always_comb begin
    s3_d = s2_q;
    s3_d = cx(s3_d, 2, 4);
    s3_d = cx(s3_d, 3, 5);
    s3_d = cx(s3_d, 1, 2);
    s3_d = cx(s3_d, 3, 4);
    s3_d = cx(s3_d, 5, 6);
  end

  // Pipeline registers and valid chain; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      vld_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      vld_q <= {vld_q[1:0], bus.in_valid};
    end
  end

  assign bus.sortOut   = s3_q;
  assign bus.out_valid = vld_q[2];

endmodule

// File: tb/tb_sorter.sv
// Scoreboard bench for sorter: stimulus pushes expected sets with a due cycle,
// and a negedge monitor pops and compares whenever out_valid is seen.
module tb_sorter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sorter_if bus ();
  sorter dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pk(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  // Reference: plain insertion sort of the eight bytes.
  function automatic logic [63:0] model(input logic [63:0] d);
    logic [7:0] a [8];
    logic [7:0] t;
    logic [63:0] r;
    for (int k = 0; k < 8; k++) a[k] = d[8*k +: 8];
    for (int k = 1; k < 8; k++) begin
      for (int m = k; m > 0; m--) begin
        if (a[m] < a[m-1]) begin
          t = a[m]; a[m] = a[m-1]; a[m-1] = t;
        end
      end
    end
    r = '0;
    for (int k = 0; k < 8; k++) begin
`ifdef SORTER_DESCENDING_EN
      r[8*k +: 8] = a[7-k];
`else
      r[8*k +: 8] = a[k];
`endif
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [63:0] e);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.sortIn   = d;
    sb.push_back('{data: e, due: cyc + 3});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.sortIn   = {$urandom, $urandom};
    end
  endtask

  // Monitor: every valid output must match the oldest pending set on its due cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missed_output: out_valid=0 required 1 at cycle %0d", sb[0].due);
        void'(sb.pop_front());
      end
      if (bus.out_valid) begin
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_valid: out_valid=1 required 0 at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          if (bus.sortOut !== e.data || cyc != e.due) begin
            n_bad++;
            $display("FAIL output: got %h at cycle %0d required %h at cycle %0d",
                     bus.sortOut, cyc, e.data, e.due);
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] d;
    bus.in_valid = 1'b0;
    bus.sortIn   = '0;
    #3;
    check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("reset_sortOut", bus.sortOut, 64'd0);
    #9 rst_n = 1'b1;
    idle(5);
    check("idle_out_valid", {63'd0, bus.out_valid}, 64'd0);

    // Single set
`ifdef SORTER_DESCENDING_EN
    send(pk(200, 3, 77, 3, 255, 0, 128, 16), pk(255, 200, 128, 77, 16, 3, 3, 0));
`else
    send(pk(200, 3, 77, 3, 255, 0, 128, 16), pk(0, 3, 3, 16, 77, 128, 200, 255));
`endif
    idle(5);

    // Back-to-back: reversed, all-equal, already sorted
`ifdef SORTER_DESCENDING_EN
    send(pk(7, 6, 5, 4, 3, 2, 1, 0), pk(7, 6, 5, 4, 3, 2, 1, 0));
    send({8{8'h5A}}, {8{8'h5A}});
    send(pk(0, 1, 2, 3, 4, 5, 6, 7), pk(7, 6, 5, 4, 3, 2, 1, 0));
`else
    send(pk(7, 6, 5, 4, 3, 2, 1, 0), pk(0, 1, 2, 3, 4, 5, 6, 7));
    send({8{8'h5A}}, {8{8'h5A}});
    send(pk(0, 1, 2, 3, 4, 5, 6, 7), pk(0, 1, 2, 3, 4, 5, 6, 7));
`endif
    idle(5);

    // Random sets with in_valid toggled
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(1) == 1) begin
        d = {$urandom, $urandom};
        send(d, model(d));
      end else begin
        idle(1);
      end
    end
    idle(5);

    // Reset mid-stream: two sets in flight are discarded
    send(pk(50, 40, 30, 20, 10, 60, 70, 80), pk(10, 20, 30, 40, 50, 60, 70, 80));
    send(pk(1, 1, 1, 1, 2, 2, 2, 2), pk(1, 1, 1, 1, 2, 2, 2, 2));
    @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("midreset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("midreset_sortOut", bus.sortOut, 64'd0);
    idle(2);
    #2 rst_n = 1'b1;
    idle(4);
    check("post_reset_idle", {63'd0, bus.out_valid}, 64'd0);
`ifdef SORTER_DESCENDING_EN
    send(pk(9, 1, 8, 2, 7, 3, 6, 4), pk(9, 8, 7, 6, 4, 3, 2, 1));
`else
    send(pk(9, 1, 8, 2, 7, 3, 6, 4), pk(1, 2, 3, 4, 6, 7, 8, 9));
`endif
    idle(6);

    check("pending_left", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
